// File: rtl/trace_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : libdbg
// Shared trace record/entry types and widths for the retirement-trace path.
// Rev     : 1.0
// ============================================================================
package libdbg;

  localparam int TS_W  = 48;
  localparam int DROPW = 16;
  localparam int TID_W = 6;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             replay;
    logic             annul;
    logic             dma_mode;
    logic             uc_mode;
    logic [3:0]       upc;
  } trace_rec_t;

  typedef struct packed {
    trace_rec_t       rec;
    logic [TS_W-1:0]  ts;
    logic             lost;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module : trace_fifo
// Per-pipe synchronous FIFO of timestamped trace entries (wrap-bit pointers).
// Rev    : 1.0
// ============================================================================
module trace_fifo
  import libdbg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         gclk,
  input  logic         rst,
  input  logic         push,
  input  trace_entry_t din,
  input  logic         pop,
  output trace_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_push;
  logic         w_do_pop;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge gclk) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/trace_arbiter.sv
`default_nettype none
// ============================================================================
// Module : trace_arbiter
// Captures per-pipe retirement records and round-robins them onto one stream.
// Rev    : 1.0
// ============================================================================
module trace_arbiter
  import libdbg::*;
#(
  parameter int NPIPE = 2,
  parameter int DEPTH = 4,
  parameter int TIDW  = 6
) (
  input  logic                        gclk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic                        cfg_drop_replay,
  input  logic                        cfg_drop_annul,
  input  logic                        cfg_clr_drops,
  input  logic [NPIPE-1:0]            in_valid,
  input  trace_rec_t [NPIPE-1:0]      in_rec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2:0]                  out_pid,
  output trace_rec_t                  out_rec,
  output logic [TS_W-1:0]             out_ts,
  output logic                        out_lost,
  output logic [NPIPE-1:0][DROPW-1:0] drop_cnt
);

  localparam int PW = (NPIPE > 1) ? $clog2(NPIPE) : 1;

  if (TIDW != TID_W) begin : g_tidw_check
    $error("trace_arbiter: TIDW must match libdbg::TID_W");
  end

  logic [TS_W-1:0]  r_ts;
  logic [PW-1:0]    r_rr;
  logic             r_out_valid;
  logic [2:0]       r_out_pid;
  trace_rec_t       r_out_rec;
  logic [TS_W-1:0]  r_out_ts;
  logic             r_out_lost;

  logic [NPIPE-1:0] w_empty;
  logic [NPIPE-1:0] w_full;
  trace_entry_t     w_dout [NPIPE];
  trace_entry_t     w_sel;
  logic [PW-1:0]    w_gnt;
  logic             w_any;
  logic             w_load;

  always_ff @(posedge gclk) begin
    if (!rst) r_ts <= '0;
    else      r_ts <= r_ts + 1'b1;
  end

  // Search order starts just after the last winner.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx = '0;
    w_gnt = r_rr;
    w_any = 1'b0;
    for (int i = 1; i <= NPIPE; i++) begin
      v_idx = PW'((int'(r_rr) + i) % NPIPE);
      if (!w_any && !w_empty[v_idx]) begin
        w_any = 1'b1;
        w_gnt = v_idx;
      end
    end
  end

  assign w_load = (~r_out_valid | out_ready) & w_any;
  assign w_sel  = w_dout[w_gnt];

  for (genvar p = 0; p < NPIPE; p++) begin : g_pipe
    logic             w_cap;
    logic             w_pop;
    logic             w_drop;
    logic             w_push;
    trace_entry_t     w_din;
    logic             r_lost;
    logic [DROPW-1:0] r_cnt;

    assign w_cap  = cfg_en & in_valid[p]
                  & ~(cfg_drop_replay & in_rec[p].replay)
                  & ~(cfg_drop_annul  & in_rec[p].annul);
    assign w_pop  = w_load & (w_gnt == PW'(p));
    assign w_drop = w_cap & w_full[p] & ~w_pop;
    assign w_push = w_cap & ~w_drop;
    assign w_din  = '{rec: in_rec[p], ts: r_ts, lost: r_lost};

    trace_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .gclk  (gclk),
      .rst   (rst),
      .push  (w_push),
      .din   (w_din),
      .pop   (w_pop),
      .dout  (w_dout[p]),
      .full  (w_full[p]),
      .empty (w_empty[p])
    );

    always_ff @(posedge gclk) begin
      if (!rst)        r_lost <= 1'b0;
      else if (w_push) r_lost <= 1'b0;
      else if (w_drop) r_lost <= 1'b1;
    end

    // A clear coinciding with a drop counts that drop.
    always_ff @(posedge gclk) begin
      if (!rst)                         r_cnt <= '0;
      else if (cfg_clr_drops)           r_cnt <= DROPW'(w_drop);
      else if (w_drop && r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
    end

    assign drop_cnt[p] = r_cnt;
  end

  always_ff @(posedge gclk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_pid   <= '0;
      r_out_rec   <= '0;
      r_out_ts    <= '0;
      r_out_lost  <= 1'b0;
      r_rr        <= PW'(NPIPE - 1);
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_pid   <= 3'(w_gnt);
      r_out_rec   <= w_sel.rec;
      r_out_ts    <= w_sel.ts;
      r_out_lost  <= w_sel.lost;
      r_rr        <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pid   = r_out_pid;
  assign out_rec   = r_out_rec;
  assign out_ts    = r_out_ts;
  assign out_lost  = r_out_lost;

endmodule
`default_nettype wire

// File: tb/tb_trace_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_trace_arbiter
// Directed vector table plus stall/overflow, saturation and reset sequences.
// Rev    : 1.0
// ============================================================================
module tb_trace_arbiter;
  import libdbg::*;

  localparam int NP = 2;

  logic                   gclk = 1'b0;
  logic                   rst;
  logic                   cfg_en;
  logic                   cfg_drop_replay;
  logic                   cfg_drop_annul;
  logic                   cfg_clr_drops;
  logic [NP-1:0]          in_valid;
  trace_rec_t [NP-1:0]    in_rec;
  logic                   out_valid;
  logic                   out_ready;
  logic [2:0]             out_pid;
  trace_rec_t             out_rec;
  logic [TS_W-1:0]        out_ts;
  logic                   out_lost;
  logic [NP-1:0][DROPW-1:0] drop_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [47:0] tb_ts;

  always #5 gclk = ~gclk;

  always @(posedge gclk) begin
    if (!rst) tb_ts <= '0;
    else      tb_ts <= tb_ts + 48'd1;
  end

  trace_arbiter #(.NPIPE(NP), .DEPTH(4), .TIDW(6)) dut (
    .gclk            (gclk),
    .rst             (rst),
    .cfg_en          (cfg_en),
    .cfg_drop_replay (cfg_drop_replay),
    .cfg_drop_annul  (cfg_drop_annul),
    .cfg_clr_drops   (cfg_clr_drops),
    .in_valid        (in_valid),
    .in_rec          (in_rec),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pid         (out_pid),
    .out_rec         (out_rec),
    .out_ts          (out_ts),
    .out_lost        (out_lost),
    .drop_cnt        (drop_cnt)
  );

  typedef struct packed {
    logic        r;
    logic        en;
    logic [1:0]  vld;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        ann0;
    logic        dann;
    logic        ev;
    logic [2:0]  epid;
    logic [31:0] epc;
    logic [47:0] ets;
  } vec_t;

  function automatic trace_rec_t mkrec(int p, logic [31:0] pc, logic ann);
    trace_rec_t rr;
    rr.tid      = 6'(p + 1);
    rr.pc       = pc;
    rr.inst     = ~pc;
    rr.replay   = 1'b0;
    rr.annul    = ann;
    rr.dma_mode = p[0];
    rr.uc_mode  = ~p[0];
    rr.upc      = pc[3:0];
    return rr;
  endfunction

  function automatic vec_t mv(logic r, logic en, logic [1:0] vld, logic [31:0] pc0,
                              logic [31:0] pc1, logic ann0, logic dann, logic ev,
                              logic [2:0] epid, logic [31:0] epc, logic [47:0] ets);
    vec_t v;
    v.r = r; v.en = en; v.vld = vld; v.pc0 = pc0; v.pc1 = pc1; v.ann0 = ann0;
    v.dann = dann; v.ev = ev; v.epid = epid; v.epc = epc; v.ets = ets;
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle();
    in_valid      = '0;
    in_rec        = '0;
    cfg_clr_drops = 1'b0;
  endtask

  vec_t        tbl [20];
  vec_t        v;
  trace_rec_t  erec;
  logic [47:0] t0, t1, t7;

  initial begin
    rst = 1'b0; cfg_en = 1'b1; cfg_drop_replay = 1'b0; cfg_drop_annul = 1'b0;
    out_ready = 1'b1;
    idle();

    //          r  en vld    pc0           pc1       a0 da  ev pid epc           ets
    tbl[0]  = mv(0, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[1]  = mv(1, 1, 2'b01, 32'h4000_0000,32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[2]  = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 1, 0, 32'h4000_0000,48'd0);
    tbl[3]  = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[4]  = mv(0, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[5]  = mv(1, 1, 2'b11, 32'h100,      32'h200,  0, 0, 0, 0, 32'h0,        48'd0);
    tbl[6]  = mv(1, 1, 2'b11, 32'h101,      32'h201,  0, 0, 1, 0, 32'h100,      48'd0);
    tbl[7]  = mv(1, 1, 2'b11, 32'h102,      32'h202,  0, 0, 1, 1, 32'h200,      48'd0);
    tbl[8]  = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 1, 0, 32'h101,      48'd1);
    tbl[9]  = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 1, 1, 32'h201,      48'd1);
    tbl[10] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 1, 0, 32'h102,      48'd2);
    tbl[11] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 1, 1, 32'h202,      48'd2);
    tbl[12] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[13] = mv(1, 1, 2'b01, 32'h300,      32'h0,    1, 1, 0, 0, 32'h0,        48'd0);
    tbl[14] = mv(1, 1, 2'b01, 32'h304,      32'h0,    0, 1, 0, 0, 32'h0,        48'd0);
    tbl[15] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 1, 0, 32'h304,      48'd9);
    tbl[16] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[17] = mv(1, 0, 2'b11, 32'h900,      32'h901,  0, 0, 0, 0, 32'h0,        48'd0);
    tbl[18] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);
    tbl[19] = mv(1, 1, 2'b00, 32'h0,        32'h0,    0, 0, 0, 0, 32'h0,        48'd0);

    for (int k = 0; k < 20; k++) begin
      v = tbl[k];
      rst = v.r; cfg_en = v.en; cfg_drop_annul = v.dann; out_ready = 1'b1;
      in_valid  = v.vld;
      in_rec[0] = mkrec(0, v.pc0, v.ann0);
      in_rec[1] = mkrec(1, v.pc1, 1'b0);
      tick();
      erec = v.ev ? mkrec(int'(v.epid), v.epc, 1'b0) : '0;
      if (v.ev || !v.r)
        chk($sformatf("vec%0d", k),
            256'({out_valid, out_pid, out_rec, out_ts, out_lost, drop_cnt}),
            256'({v.ev, v.epid, erec, v.ets, 1'b0, 32'h0}));
      else
        chk($sformatf("vec%0d_idle", k), 256'({out_valid, drop_cnt}), 256'({1'b0, 32'h0}));
    end
    idle(); cfg_drop_annul = 1'b0; cfg_en = 1'b1;

    // Stall with pipe0 record held in the output, then overflow pipe1.
    out_ready = 1'b0;
    in_valid = 2'b01; in_rec[0] = mkrec(0, 32'h4FF, 1'b0); t0 = tb_ts;
    tick();
    idle();
    t1 = '0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 2'b10; in_rec[1] = mkrec(1, 32'h500 + 32'(i), 1'b0);
      if (i == 0) t1 = tb_ts;
      tick();
      chk($sformatf("stall_hold%0d", i),
          256'({out_valid, out_pid, out_rec, out_ts, out_lost}),
          256'({1'b1, 3'd0, mkrec(0, 32'h4FF, 1'b0), t0, 1'b0}));
    end
    idle();
    chk("overflow_cnt", 256'({drop_cnt[1], drop_cnt[0]}), 256'({16'd3, 16'd0}));

    out_ready = 1'b1;
    in_valid = 2'b10; in_rec[1] = mkrec(1, 32'h507, 1'b0); t7 = tb_ts;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain%0d", i),
          256'({out_valid, out_pid, out_rec, out_ts, out_lost}),
          256'({1'b1, 3'd1, mkrec(1, (i < 4) ? 32'h500 + 32'(i) : 32'h507, 1'b0),
                (i < 4) ? t1 + 48'(i) : t7, (i == 4)}));
      tick();
    end
    chk("drain_empty", 256'({out_valid, drop_cnt[1]}), 256'({1'b0, 16'd3}));

    // Saturate pipe0's drop counter, then clear together with a drop.
    out_ready = 1'b0;
    in_valid = 2'b01; in_rec[0] = mkrec(0, 32'h800, 1'b0);
    for (int i = 0; i < 65539; i++) tick();
    chk("sat_fffe", 256'(drop_cnt[0]), 256'(16'hFFFE));
    tick();
    chk("sat_ffff", 256'(drop_cnt[0]), 256'(16'hFFFF));
    tick();
    chk("sat_hold", 256'(drop_cnt[0]), 256'(16'hFFFF));
    cfg_clr_drops = 1'b1;
    tick();
    chk("clr_collide", 256'({drop_cnt[1], drop_cnt[0]}), 256'({16'd0, 16'd1}));
    in_valid = '0;
    tick();
    chk("clr_plain", 256'(drop_cnt[0]), 256'(16'd0));
    idle();

    // Reset while a record is held and pipe0's FIFO is full.
    rst = 1'b0;
    tick();
    chk("midrst", 256'({out_valid, out_pid, out_rec, out_ts, out_lost, drop_cnt}), 256'(0));
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 2'b11;
    in_rec[0] = mkrec(0, 32'h600, 1'b0);
    in_rec[1] = mkrec(1, 32'h700, 1'b0);
    tick();
    idle();
    tick();
    chk("post_rst_p0", 256'({out_valid, out_pid, out_rec, out_ts, out_lost}),
        256'({1'b1, 3'd0, mkrec(0, 32'h600, 1'b0), 48'd0, 1'b0}));
    tick();
    chk("post_rst_p1", 256'({out_valid, out_pid, out_rec, out_ts, out_lost}),
        256'({1'b1, 3'd1, mkrec(1, 32'h700, 1'b0), 48'd0, 1'b0}));
    tick();
    chk("post_rst_empty", 256'({out_valid, drop_cnt}), 256'({1'b0, 32'h0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Synthesizable retirement-trace collector. It captures committed-instruction records from NPIPE pipeline write-back stages and buffers them per pipeline.
- It round-robin arbitrates the buffered records onto one valid/ready trace stream feeding the host debug/DMA link.
- It replaces simulation-only disassembly with an on-FPGA trace path, including filtering, timestamping and loss accounting.

Parameters:
NPIPE, 2, number of pipelines feeding trace (1..8)
DEPTH, 4, per-pipeline FIFO entries (power of 2, >=2)
TIDW, 6, thread-ID width

Ports:
gclk  in  1  clock
rst  in  1  reset, synchronous, active-low
cfg_en  in  1  capture enable
cfg_drop_replay  in  1  discard records with replay=1
cfg_drop_annul  in  1  discard records with annul=1
cfg_clr_drops  in  1  one-cycle pulse; clears all drop counters
in_valid  in  NPIPE  per-pipe retirement strobe (upstream already qualified by (run|dma_mode) & !icmiss)
in_rec  in  NPIPE x trace_rec_t  per-pipe record {tid, pc[31:0], inst[31:0], replay, annul, dma_mode, uc_mode, upc[3:0]}
out_valid  out  1  trace word valid
out_ready  in  1  consumer accept
out_pid  out  3  source pipeline index
out_rec  out  trace_rec_t  record
out_ts  out  48  capture timestamp
out_lost  out  1  one or more records from this pipe were dropped before this one
drop_cnt  out  NPIPE x 16  per-pipe drop counters, saturating

Behaviour:
- Reset (rst=0 at a gclk edge):
  - out_valid=0; out_pid, out_rec, out_ts and out_lost =0.
  - All FIFOs empty; drop_cnt=0; lost flags=0; timestamp=0.
  - RR pointer=NPIPE-1, so pipe 0 wins first.
  - Reset mid-transfer discards all buffered and held records without handshake.
- Timestamp: 48-bit free-running counter, +1 every cycle out of reset, wraps to 0.
- Capture condition per pipe p: cfg_en & in_valid[p] & !(cfg_drop_replay & replay) & !(cfg_drop_annul & annul).
  - Filtered or disabled records are neither stored nor counted as drops.
- Push: a captured record is written to FIFO p on the same edge, tagged with the current timestamp and lost[p].
  - lost[p] clears on that edge.
- Overflow: a capture into a full FIFO p that is not popped in the same cycle is dropped.
  - drop_cnt[p] increments, saturating at 0xFFFF.
  - lost[p] sets.
- A full FIFO with simultaneous pop and push accepts the push; no drop.
- cfg_clr_drops: all counters go to 0. A drop in the same cycle as a clear leaves that counter =1. lost flags are unaffected.
- Output register load condition: (!out_valid | out_ready) & any FIFO non-empty.
  - Grant goes to the first non-empty pipe searching rr+1, rr+2, ... modulo NPIPE.
  - The winner is popped into the output register, and rr becomes the winner.
- While out_valid & !out_ready, all out_* fields hold stable. The RR pointer does not move.
- Throughput: one record per cycle under continuous out_ready.
- Latency: a record sampled in cycle 0 is written to the FIFO at the end of cycle 0. out_valid asserts in cycle 2 when its FIFO was empty and the output was free.
- Empty condition: no FIFO non-empty and the output handshake completes -> out_valid=0 next cycle.
- Ordering: per-pipe order is preserved. Cross-pipe order follows arbitration only; the consumer reorders using out_ts.
- cfg_en deassertion stops new captures only. Buffered records continue to drain.

Decomposition:
- Package libdbg holds:
  - trace_rec_t (packed struct above)
  - trace_entry_t = {trace_rec_t, ts[47:0], lost}
  - constants TS_W=48 and DROPW=16
- Sub-module trace_fifo (one instance per pipe): synchronous FIFO of trace_entry_t with push, pop, full, empty, DEPTH entries, and pointer wrap via an extra MSB.
- The arbiter, output register, timestamp, lost flags and counters live in trace_arbiter.

Test Plan:
- Single record: after reset, pipe0 in_valid one cycle with pc=0x40000000, cfg_en=1, out_ready=1 -> out_valid in cycle 2, out_pid=0, out_rec.pc=0x40000000, out_ts=capture cycle, out_lost=0.
- Round-robin: NPIPE=2, both pipes push 3 records in the same cycles with out_ready=1 -> out_pid sequence 0,1,0,1,0,1 with no gaps.
- Backpressure and overflow: out_ready=0, pipe1 pushes DEPTH+3=7 records -> drop_cnt[1]=3. Then out_ready=1 and one more push -> 4 records out with out_lost=0, then the fifth out (the 8th push) with out_lost=1. out_* hold stable while stalled.
- Filtering: cfg_drop_annul=1, push annul=1 then annul=0 -> only the second record emitted; drop_cnt unchanged.
- Clear/drop collision and saturation: force drop_cnt[0] to 0xFFFF via 65535+ drops, then one more drop -> stays 0xFFFF. Then cfg_clr_drops together with a drop -> drop_cnt[0]=1.
- Reset mid-operation: rst=0 while out_valid=1 and FIFOs hold 2 entries -> next cycle out_valid=0, drop_cnt=0. After release, the first grant goes to pipe 0.
